// File: rtl/pd_rx_framer.sv
// USB-PD BMC receive framer. Hunts SOP*/Hard Reset/Cable Reset ordered sets
// in an aligned 4b5b symbol stream, then packs data nibbles into bytes until EOP.
// Only data codes flush the ordered-set window. Invalid codes are shifted in, so
// a single corrupted symbol can still be tolerated as a mismatched position.
module pd_rx_framer #(
  parameter int MAX_BYTES = 64,
  parameter int IDLE_TO   = 255,
  parameter int SOP_TOL   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       sym_valid,
  input  logic [4:0] sym,
  output logic       frame_start,
  output logic [1:0] sop_type,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic [8:0] byte_cnt,
  output logic       frame_end,
  output logic       frame_err,
  output logic [2:0] err_code,
  output logic       hrst_det,
  output logic       crst_det,
  output logic       busy
);

  localparam logic [4:0] K_S1  = 5'b11000;
  localparam logic [4:0] K_S2  = 5'b10001;
  localparam logic [4:0] K_S3  = 5'b00110;
  localparam logic [4:0] K_R1  = 5'b00111;
  localparam logic [4:0] K_R2  = 5'b11001;
  localparam logic [4:0] K_EOP = 5'b01101;
  localparam int GW = $clog2(IDLE_TO + 1);

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  state_t          state;
  logic [3:0][4:0] win;
  logic [3:0][4:0] win_nx;
  logic [GW-1:0]   gap;
  logic [3:0]      lo_nib;

  logic            is_data;
  logic            is_k;
  logic [3:0]      nib;
  logic [2:0]      os_sel;  // 0 none, 1 HR, 2 CR, 3 SOP, 4 SOP', 5 SOP''

  function automatic logic [2:0] n_eq(input logic [3:0][4:0] w,
                                      input logic [4:0] p0, input logic [4:0] p1,
                                      input logic [4:0] p2, input logic [4:0] p3);
    return {2'b0, w[0] == p0} + {2'b0, w[1] == p1} +
           {2'b0, w[2] == p2} + {2'b0, w[3] == p3};
  endfunction

  // Classify the incoming symbol as data nibble, K-code or invalid.
  always_comb begin
    is_data = 1'b1;
    nib     = 4'h0;
    case (sym)
      5'b11110: nib = 4'h0;
      5'b01001: nib = 4'h1;
      5'b10100: nib = 4'h2;
      5'b10101: nib = 4'h3;
      5'b01010: nib = 4'h4;
      5'b01011: nib = 4'h5;
      5'b01110: nib = 4'h6;
      5'b01111: nib = 4'h7;
      5'b10010: nib = 4'h8;
      5'b10011: nib = 4'h9;
      5'b10110: nib = 4'hA;
      5'b10111: nib = 4'hB;
      5'b11010: nib = 4'hC;
      5'b11011: nib = 4'hD;
      5'b11100: nib = 4'hE;
      5'b11101: nib = 4'hF;
      default:  is_data = 1'b0;
    endcase
    is_k = (sym == K_S1) || (sym == K_S2) || (sym == K_S3) ||
           (sym == K_R1) || (sym == K_R2) || (sym == K_EOP);
  end

  // Match the window as it would look with this symbol shifted in; exact beats tolerant.
  always_comb begin
    logic [2:0] c [5];
    win_nx = {sym, win[3], win[2], win[1]};
    c[0] = n_eq(win_nx, K_R1, K_R1, K_R1, K_R2);
    c[1] = n_eq(win_nx, K_R1, K_S1, K_R1, K_S3);
    c[2] = n_eq(win_nx, K_S1, K_S1, K_S1, K_S2);
    c[3] = n_eq(win_nx, K_S1, K_S1, K_S3, K_S3);
    c[4] = n_eq(win_nx, K_S1, K_S3, K_S1, K_S3);
    os_sel = 3'd0;
    if (SOP_TOL != 0) begin
      if      (c[0] >= 3'd3) os_sel = 3'd1;
      else if (c[1] >= 3'd3) os_sel = 3'd2;
      else if (c[2] >= 3'd3) os_sel = 3'd3;
      else if (c[3] >= 3'd3) os_sel = 3'd4;
      else if (c[4] >= 3'd3) os_sel = 3'd5;
    end
    if      (c[0] == 3'd4) os_sel = 3'd1;
    else if (c[1] == 3'd4) os_sel = 3'd2;
    else if (c[2] == 3'd4) os_sel = 3'd3;
    else if (c[3] == 3'd4) os_sel = 3'd4;
    else if (c[4] == 3'd4) os_sel = 3'd5;
  end

  assign busy = (state != IDLE);

  // Framer FSM with registered pulse outputs, gap timer and byte packing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      win         <= '0;
      gap         <= '0;
      lo_nib      <= '0;
      frame_start <= 1'b0;
      sop_type    <= '0;
      byte_valid  <= 1'b0;
      byte_data   <= '0;
      byte_cnt    <= '0;
      frame_end   <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= '0;
      hrst_det    <= 1'b0;
      crst_det    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      byte_valid  <= 1'b0;
      frame_end   <= 1'b0;
      frame_err   <= 1'b0;
      hrst_det    <= 1'b0;
      crst_det    <= 1'b0;
      if (!en) begin
        state    <= IDLE;
        win      <= '0;
        gap      <= '0;
        byte_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            gap <= '0;
            if (sym_valid) begin
              if (is_data) begin
                win <= '0;
              end else begin
                case (os_sel)
                  3'd1: begin hrst_det <= 1'b1; win <= '0; end
                  3'd2: begin crst_det <= 1'b1; win <= '0; end
                  3'd3, 3'd4, 3'd5: begin
                    frame_start <= 1'b1;
                    sop_type    <= 2'(os_sel - 3'd3);
                    byte_cnt    <= '0;
                    win         <= '0;
                    state       <= LO;
                  end
                  default: win <= win_nx;
                endcase
              end
            end
          end
          default: begin
            if (sym_valid) begin
              gap <= '0;
              if (is_data) begin
                if (state == LO) begin
                  lo_nib <= nib;
                  state  <= HI;
                end else if (byte_cnt == 9'(MAX_BYTES)) begin
                  frame_err <= 1'b1;
                  err_code  <= 3'd4;
                  state     <= IDLE;
                end else begin
                  byte_valid <= 1'b1;
                  byte_data  <= {nib, lo_nib};
                  byte_cnt   <= byte_cnt + 9'd1;
                  state      <= LO;
                end
              end else if (sym == K_EOP) begin
                if (state == LO) frame_end <= 1'b1;
                else begin
                  frame_err <= 1'b1;
                  err_code  <= 3'd3;
                end
                state <= IDLE;
              end else begin
                frame_err <= 1'b1;
                err_code  <= is_k ? 3'd2 : 3'd1;
                state     <= IDLE;
              end
            end else if (gap == GW'(IDLE_TO)) begin
              frame_err <= 1'b1;
              err_code  <= 3'd5;
              gap       <= '0;
              state     <= IDLE;
            end else begin
              gap <= gap + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pd_rx_framer.sv
// Directed bench for pd_rx_framer: expected output events are queued as symbols
// are driven and compared against DUT pulses by a negedge monitor.
module tb_pd_rx_framer;

  localparam int MAXB = 64;
  localparam int ITO  = 255;

  localparam logic [4:0] S1 = 5'b11000, S2 = 5'b10001, S3 = 5'b00110;
  localparam logic [4:0] R1 = 5'b00111, R2 = 5'b11001, EOP = 5'b01101;
  localparam logic [4:0] BAD = 5'b00000;

  localparam logic [3:0] E_START = 4'd1, E_BYTE = 4'd2, E_END = 4'd3,
                         E_ERR = 4'd4, E_HRST = 4'd5, E_CRST = 4'd6;

  logic       clk = 1'b0;
  logic       rst_n, en, sym_valid;
  logic [4:0] sym;
  logic       frame_start, byte_valid, frame_end, frame_err, hrst_det, crst_det, busy;
  logic [1:0] sop_type;
  logic [7:0] byte_data;
  logic [8:0] byte_cnt;
  logic [2:0] err_code;

  int checks = 0;
  int errors = 0;

  logic [23:0] sbq [$];
  logic [23:0] obs, expv;
  int          npulse;
  logic [4:0]  dc [16];

  pd_rx_framer #(.MAX_BYTES(MAXB), .IDLE_TO(ITO), .SOP_TOL(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sym_valid(sym_valid), .sym(sym),
    .frame_start(frame_start), .sop_type(sop_type), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_cnt(byte_cnt), .frame_end(frame_end),
    .frame_err(frame_err), .err_code(err_code), .hrst_det(hrst_det),
    .crst_det(crst_det), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] ev(input logic [3:0] k, input logic [8:0] cnt,
                                     input logic [7:0] d);
    return {k, 3'b000, cnt, d};
  endfunction

  // Monitor: every DUT pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_n) begin
      npulse = int'(frame_start) + int'(byte_valid) + int'(frame_end) +
               int'(frame_err) + int'(hrst_det) + int'(crst_det);
      if (npulse > 0) begin
        checks++;
        assert (npulse == 1) else begin
          errors++;
          $error("FAIL one_pulse observed=%0d expected=1", npulse);
        end
        obs = '0;
        if (frame_start) obs = ev(E_START, 9'd0, {6'b0, sop_type});
        else if (byte_valid) obs = ev(E_BYTE, byte_cnt, byte_data);
        else if (frame_end) obs = ev(E_END, byte_cnt, 8'h00);
        else if (frame_err) obs = ev(E_ERR, 9'd0, {5'b0, err_code});
        else if (hrst_det) obs = ev(E_HRST, 9'd0, 8'h00);
        else obs = ev(E_CRST, 9'd0, 8'h00);
        checks++;
        if (sbq.size() == 0) expv = '1;
        else expv = sbq.pop_front();
        assert (obs === expv) else begin
          errors++;
          $error("FAIL event observed=%h expected=%h", obs, expv);
        end
      end
    end
  end

  task automatic send(input logic [4:0] s);
    sym = s;
    sym_valid = 1'b1;
    @(posedge clk);
    #1;
    sym_valid = 1'b0;
    sym = 5'b0;
  endtask

  task automatic send_os(input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] c, input logic [4:0] d);
    send(a); send(b); send(c); send(d);
  endtask

  task automatic drain(input string tag, input int lim);
    int k;
    k = 0;
    while (sbq.size() != 0 && k < lim) begin
      @(negedge clk);
      k++;
    end
    checks++;
    assert (sbq.size() == 0) else begin
      errors++;
      $error("FAIL %s pending observed=%0d expected=0", tag, sbq.size());
      sbq.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  initial begin
    logic [3:0] lo, hi;
    int idx;
    dc = '{5'b11110, 5'b01001, 5'b10100, 5'b10101, 5'b01010, 5'b01011, 5'b01110, 5'b01111,
           5'b10010, 5'b10011, 5'b10110, 5'b10111, 5'b11010, 5'b11011, 5'b11100, 5'b11101};
    rst_n = 1'b0; en = 1'b0; sym_valid = 1'b0; sym = 5'b0;
    #22;
    chk("reset_outputs", 32'({frame_start, sop_type, byte_valid, byte_data, byte_cnt, frame_end,
                              frame_err, err_code, hrst_det, crst_det, busy}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; en = 1'b1;
    @(posedge clk); #1;

    // T1: SOP, bytes 0x21 0x43, clean EOP
    sbq.push_back(ev(E_START, 9'd0, 8'd0));
    send_os(S1, S1, S1, S2);
    chk("t1_busy", 32'(busy), 32'd1);
    send(dc[1]); send(dc[2]);
    sbq.push_back(ev(E_BYTE, 9'd1, 8'h21));
    send(dc[3]); send(dc[4]);
    sbq.push_back(ev(E_BYTE, 9'd2, 8'h43));
    sbq.push_back(ev(E_END, 9'd2, 8'h00));
    send(EOP);
    drain("t1", 10);
    chk("t1_byte_cnt", 32'(byte_cnt), 32'd2);

    // T2: SOP' exact with zero-length frame, then SOP'' with corrupted first Sync
    sbq.push_back(ev(E_START, 9'd0, 8'd1));
    send_os(S1, S1, S3, S3);
    sbq.push_back(ev(E_END, 9'd0, 8'h00));
    send(EOP);
    drain("t2a", 10);
    sbq.push_back(ev(E_START, 9'd0, 8'd2));
    send_os(BAD, S3, S1, S3);
    send(dc[10]); send(dc[5]);
    sbq.push_back(ev(E_BYTE, 9'd1, 8'h5A));
    sbq.push_back(ev(E_END, 9'd1, 8'h00));
    send(EOP);
    drain("t2b", 10);
    chk("t2_sop_type_held", 32'(sop_type), 32'd2);

    // T3: Hard Reset and Cable Reset ordered sets
    sbq.push_back(ev(E_HRST, 9'd0, 8'h00));
    send_os(R1, R1, R1, R2);
    chk("t3_busy_hr", 32'(busy), 32'd0);
    drain("t3a", 10);
    sbq.push_back(ev(E_CRST, 9'd0, 8'h00));
    send_os(R1, S1, R1, S3);
    chk("t3_busy_cr", 32'(busy), 32'd0);
    drain("t3b", 10);

    // T4: odd nibble at EOP, invalid code, K-code in data
    sbq.push_back(ev(E_START, 9'd0, 8'd0));
    sbq.push_back(ev(E_ERR, 9'd0, 8'd3));
    send_os(S1, S1, S1, S2); send(dc[5]); send(EOP);
    drain("t4_odd", 10);
    sbq.push_back(ev(E_START, 9'd0, 8'd0));
    sbq.push_back(ev(E_ERR, 9'd0, 8'd1));
    send_os(S1, S1, S1, S2); send(dc[1]); send(BAD);
    drain("t4_inv", 10);
    sbq.push_back(ev(E_START, 9'd0, 8'd0));
    sbq.push_back(ev(E_ERR, 9'd0, 8'd2));
    send_os(S1, S1, S1, S2); send(dc[0]); send(S1);
    drain("t4_k", 10);
    chk("t4_busy", 32'(busy), 32'd0);

    // T5: overflow on byte MAXB+1
    sbq.push_back(ev(E_START, 9'd0, 8'd0));
    send_os(S1, S1, S1, S2);
    lo = 4'h0;
    for (int i = 0; i < 2 * MAXB + 2; i++) begin
      hi = 4'(i % 16);
      if (i % 2 == 1) begin
        idx = i / 2 + 1;
        if (idx <= MAXB) sbq.push_back(ev(E_BYTE, 9'(idx), {hi, lo}));
        else sbq.push_back(ev(E_ERR, 9'd0, 8'd4));
      end
      lo = hi;
      send(dc[i % 16]);
    end
    drain("t5", 10);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_byte_cnt", 32'(byte_cnt), 32'(MAXB));

    // en low ends a frame silently
    sbq.push_back(ev(E_START, 9'd0, 8'd0));
    send_os(S1, S1, S1, S2); send(dc[7]);
    en = 1'b0;
    @(posedge clk); #1;
    chk("en_busy", 32'(busy), 32'd0);
    chk("en_byte_cnt", 32'(byte_cnt), 32'd0);
    en = 1'b1;
    send(dc[8]); send(EOP);
    drain("en", 10);

    // T6: timeout, then reset mid-frame
    sbq.push_back(ev(E_START, 9'd0, 8'd0));
    send_os(S1, S1, S1, S2);
    send(dc[6]); send(dc[9]);
    sbq.push_back(ev(E_BYTE, 9'd1, 8'h96));
    sbq.push_back(ev(E_ERR, 9'd0, 8'd5));
    send(dc[3]);
    drain("t6_timeout", ITO + 20);
    chk("t6_busy", 32'(busy), 32'd0);
    sbq.push_back(ev(E_START, 9'd0, 8'd0));
    send_os(S1, S1, S1, S2);
    send(dc[2]); send(dc[4]);
    sbq.push_back(ev(E_BYTE, 9'd1, 8'h42));
    send(dc[1]);
    drain("t6_pre_reset", 10);
    rst_n = 1'b0;
    #1;
    chk("t6_reset_outputs", 32'({frame_start, sop_type, byte_valid, byte_data, byte_cnt, frame_end,
                                 frame_err, err_code, hrst_det, crst_det, busy}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    sbq.push_back(ev(E_START, 9'd0, 8'd1));
    send_os(S1, S1, S3, S3);
    send(dc[12]); send(dc[11]);
    sbq.push_back(ev(E_BYTE, 9'd1, 8'hBC));
    sbq.push_back(ev(E_END, 9'd1, 8'h00));
    send(EOP);
    drain("t6_after_reset", 10);
    repeat (5) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
